dq_pi_ctrl: RTL and testbench

Dual-axis PI current regulator that sits directly downstream of the Park transform.
- Consumes the d/q current pair and its one-cycle valid pulse.
- Produces d/q voltage commands for the inverse Park stage.
- Uses one shared signed multiplier, time-multiplexed by an FSM: four products per update (kp·ed, ki·ed, kp·eq, ki·eq).
- Integrators are clamped to the output limit for anti-windup.

---
 rtl/dq_pi_ctrl.sv | 103 ++++++++++
 tb/tb_dq_pi_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dq_pi_ctrl.sv
// dq_pi_ctrl: dual-axis PI current regulator sharing one signed multiplier across four products per update
module dq_pi_ctrl #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_vld,
  input  logic signed [W-1:0] id_meas,
  input  logic signed [W-1:0] iq_meas,
  input  logic signed [W-1:0] id_ref,
  input  logic signed [W-1:0] iq_ref,
  input  logic signed [W-1:0] kp,
  input  logic signed [W-1:0] ki,
  input  logic        [W-2:0] out_lim,
  output logic                busy,
  output logic                oe,
  output logic signed [W-1:0] vd,
  output logic signed [W-1:0] vq
);
  typedef enum logic [2:0] {IDLE, ERR, DP, DI, QP, QI, SUM} state_t;
  localparam logic signed [W:0]     MX1  = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MX2  = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   VMAX = {1'b0, {(W-1){1'b1}}};
  function automatic logic signed [W-1:0] sat1(input logic signed [W:0] x);
    return (x > MX1) ? VMAX : (x < -MX1) ? -VMAX : x[W-1:0];
  endfunction
  function automatic logic signed [W-1:0] sat2(input logic signed [2*W-1:0] x);
    return (x > MX2) ? VMAX : (x < -MX2) ? -VMAX : x[W-1:0];
  endfunction
  function automatic logic signed [W-1:0] clamp(input logic signed [W:0] x, input logic [W-2:0] l);
    logic signed [W:0] lp;
    logic signed [W:0] ln;
    lp = {2'b00, l};
    ln = -lp;
    return (x > lp) ? lp[W-1:0] : (x < ln) ? ln[W-1:0] : x[W-1:0];
  endfunction
  state_t state, state_nx;
  logic signed [W-1:0] idm, iqm, idr, iqr, kp_r, ki_r, ed, eq, pd, pq, acc_d, acc_q;
  logic        [W-2:0] lim_r;
  logic signed [W-1:0] ma, mb, term, acc_nx;
  logic signed [2*W-1:0] prod;
  assign busy = state != IDLE;
  // one multiplier: state selects gain (kp in P states, ki in I states) and axis error
  assign ma     = (state == DP || state == QP) ? kp_r : ki_r;
  assign mb     = (state == DP || state == DI) ? ed : eq;
  assign prod   = (2*W)'(ma) * (2*W)'(mb);
  assign term   = sat2(prod >>> FRAC);
  assign acc_nx = clamp((W+1)'(state == DI ? acc_d : acc_q) + (W+1)'(term), lim_r);
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (en && in_vld) ? ERR : IDLE;
      ERR:     state_nx = DP;
      DP:      state_nx = DI;
      DI:      state_nx = QP;
      QP:      state_nx = QI;
      QI:      state_nx = SUM;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      oe    <= 1'b0;
      vd    <= '0;
      vq    <= '0;
      acc_d <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nx;
      oe    <= state == SUM;
      if (state == IDLE && !en) begin
        acc_d <= '0;
        acc_q <= '0;
        vd    <= '0;
        vq    <= '0;
      end
      if (state == IDLE && en && in_vld) begin
        idm   <= id_meas;
        iqm   <= iq_meas;
        idr   <= id_ref;
        iqr   <= iq_ref;
        kp_r  <= kp;
        ki_r  <= ki;
        lim_r <= out_lim;
      end
      if (state == ERR) begin
        ed <= sat1((W+1)'(idr) - (W+1)'(idm));
        eq <= sat1((W+1)'(iqr) - (W+1)'(iqm));
      end
      if (state == DP) pd <= term;
      if (state == DI) acc_d <= acc_nx;
      if (state == QP) pq <= term;
      if (state == QI) acc_q <= acc_nx;
      if (state == SUM) begin
        vd <= clamp((W+1)'(pd) + (W+1)'(acc_d), lim_r);
        vq <= clamp((W+1)'(pq) + (W+1)'(acc_q), lim_r);
      end
    end
  end
endmodule

// File: tb/tb_dq_pi_ctrl.sv
// tb_dq_pi_ctrl: table-driven directed checks of dq_pi_ctrl plus hand-written multi-cycle sequences
module tb_dq_pi_ctrl;
  localparam int W = 16;
  typedef struct {
    int clr;
    int idr, idm, iqr, iqm, kp, ki, lim;
    int evd, evq;
  } vec_t;
  logic clk = 1'b0;
  logic rst, en, in_vld, busy, oe;
  logic signed [W-1:0] id_meas, iq_meas, id_ref, iq_ref, kp, ki, vd, vq;
  logic [W-2:0] out_lim;
  int checks = 0, failures = 0;
  vec_t tbl[17];
  always #5 clk = ~clk;
  dq_pi_ctrl #(.W(W), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld),
    .id_meas(id_meas), .iq_meas(iq_meas), .id_ref(id_ref), .iq_ref(iq_ref),
    .kp(kp), .ki(ki), .out_lim(out_lim),
    .busy(busy), .oe(oe), .vd(vd), .vq(vq)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input vec_t v);
    en      = 1'b1;
    id_ref  = 16'(v.idr);
    id_meas = 16'(v.idm);
    iq_ref  = 16'(v.iqr);
    iq_meas = 16'(v.iqm);
    kp      = 16'(v.kp);
    ki      = 16'(v.ki);
    out_lim = 15'(v.lim);
  endtask
  // pulse in_vld, then watch 10 edges for oe position/count and busy shape
  task automatic update(output int oe_at, output int n_oe, output int busy_bad);
    oe_at = -1;
    n_oe = 0;
    busy_bad = 0;
    in_vld = 1'b1;
    tick;
    in_vld = 1'b0;
    if (busy !== 1'b1) busy_bad++;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (oe === 1'b1) begin
        n_oe++;
        oe_at = k;
      end
      if (busy !== (k < 6)) busy_bad++;
    end
  endtask
  initial begin
    int oe_at, n_oe, busy_bad;
    tbl = '{
      '{0, 1000, 400, -500, 0, 4096, 0, 32767, 600, -500},
      '{0, -3, 0, -500, 0, 2048, 0, 32767, -2, -250},
      '{0, 100, 0, -100, 0, 0, 2048, 32767, 50, -50},
      '{0, 100, 0, -100, 0, 0, 2048, 32767, 100, -100},
      '{0, 100, 0, -100, 0, 0, 2048, 32767, 150, -150},
      '{0, 100, 0, -100, 0, 0, 2048, 32767, 200, -200},
      '{1, 800, 0, -800, 0, 0, 4096, 1000, 800, -800},
      '{0, 800, 0, -800, 0, 0, 4096, 1000, 1000, -1000},
      '{0, 800, 0, -800, 0, 0, 4096, 1000, 1000, -1000},
      '{0, -300, 0, 300, 0, 0, 4096, 1000, 700, -700},
      '{1, 32767, -32768, -32768, 32767, 4096, 0, 32767, 32767, -32767},
      '{0, -32768, 32767, 32767, -32768, 4096, 0, 32767, -32767, 32767},
      '{0, 500, 0, -500, 0, 4096, 4096, 0, 0, 0},
      '{0, 10, 0, -10, 0, 0, 4096, 32767, 10, -10},
      '{0, 7, 0, 5, 0, -4096, 0, 32767, 3, -15},
      '{0, 5, 0, -5, 0, 6144, 0, 32767, 17, -18},
      '{0, 20000, 0, -20000, 0, 32767, 0, 32767, 32767, -32767}
    };
    set_in(tbl[0]);
    rst = 1'b1;
    in_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = ~in_vld;
      tick;
      chk("rst_oe", int'(oe), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_vd", int'(vd), 0);
      chk("rst_vq", int'(vq), 0);
    end
    rst = 1'b0;
    in_vld = 1'b0;
    tick;
    oe_at = -1;
    n_oe = 0;
    busy_bad = 0;
    in_vld = 1'b1;
    tick;
    if (busy !== 1'b1) busy_bad++;
    for (int k = 1; k <= 10; k++) begin
      in_vld = (k == 3);
      if (k == 3) id_meas = 16'sd0;
      tick;
      if (oe === 1'b1) begin
        n_oe++;
        oe_at = k;
      end
      if (busy !== (k < 6)) busy_bad++;
    end
    in_vld = 1'b0;
    chk("busy_oe_count", n_oe, 1);
    chk("busy_oe_at", oe_at, 6);
    chk("busy_shape", busy_bad, 0);
    chk("busy_vd_latched", int'(vd), 600);
    chk("busy_vq", int'(vq), -500);
    set_in('{0, 200, 0, 0, 0, 4096, 0, 32767, 0, 0});
    oe_at = -1;
    in_vld = 1'b1;
    tick;
    in_vld = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) en = 1'b0;
      tick;
      if (oe === 1'b1) oe_at = k;
    end
    chk("endrop_oe_at", oe_at, 6);
    chk("endrop_vd_done", int'(vd), 200);
    tick;
    chk("endrop_vd_clr", int'(vd), 0);
    chk("endrop_vq_clr", int'(vq), 0);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].clr != 0) begin
        en = 1'b0;
        tick;
        chk($sformatf("v%0d_clr_vd", i), int'(vd), 0);
        chk($sformatf("v%0d_clr_vq", i), int'(vq), 0);
      end
      set_in(tbl[i]);
      update(oe_at, n_oe, busy_bad);
      chk($sformatf("v%0d_vd", i), int'(vd), tbl[i].evd);
      chk($sformatf("v%0d_vq", i), int'(vq), tbl[i].evq);
      chk($sformatf("v%0d_oe_at", i), oe_at, 6);
      chk($sformatf("v%0d_oe_count", i), n_oe, 1);
      chk($sformatf("v%0d_busy", i), busy_bad, 0);
    end
    set_in('{0, 100, 0, 0, 0, 0, 4096, 32767, 0, 0});
    in_vld = 1'b1;
    tick;
    in_vld = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_vd", int'(vd), 0);
    n_oe = 0;
    for (int k = 0; k < 8; k++) begin
      if (oe === 1'b1) n_oe++;
      tick;
    end
    chk("rstmid_no_oe", n_oe, 0);
    update(oe_at, n_oe, busy_bad);
    chk("rstmid_acc_vd", int'(vd), 100);
    chk("rstmid_acc_vq", int'(vq), 0);
    chk("rstmid_oe_at", oe_at, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
